// File: rtl/univ_rotate_pkg.sv
// Shared types and helpers for the rotate-align receive path.
// Provides the alignment FSM state type, the address-width derivation and a width-generic left rotate.
package univ_rotate_pkg;

    localparam int unsigned MAX_DW = 64;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_e;

    function automatic int unsigned aw_of(input int unsigned dw);
        return (dw > 1) ? $clog2(dw) : 1;
    endfunction

    // Rotates the low dw bits of word left by amt (amt < dw); bits above dw come back as zero.
    function automatic logic [MAX_DW-1:0] rotl(input logic [MAX_DW-1:0] word,
                                               input int unsigned     amt,
                                               input int unsigned     dw);
        logic [MAX_DW-1:0] mask;
        logic [MAX_DW-1:0] w;
        mask = (dw >= MAX_DW) ? '1 : ((MAX_DW'(1) << dw) - MAX_DW'(1));
        w    = word & mask;
        return ((w << amt) | (w >> (dw - amt))) & mask;
    endfunction

endpackage

// File: rtl/univ_rot_find.sv
// Combinational matcher: smallest rotation r with rotl(i_word, r) == SYNC_PAT.
// Every rotation is compared in parallel; the lowest matching amount wins.
module univ_rot_find
    import univ_rotate_pkg::*;
#(
    parameter int unsigned     DW       = 8,
    parameter logic [DW-1:0]   SYNC_PAT = DW'(8'hB1),
    localparam int unsigned    AW       = aw_of(DW)
) (
    input  logic [DW-1:0] i_word,
    output logic          o_found,
    output logic [AW-1:0] o_r
);

    always_comb begin
        // NOTE: every output gets a value before any branch so no path can infer a latch.
        o_found = 1'b0;
        o_r     = '0;
        for (int unsigned k = 0; k < DW; k++) begin
            if (!o_found && (DW'(rotl(MAX_DW'(i_word), k, DW)) == SYNC_PAT)) begin
                o_found = 1'b1;
                o_r     = AW'(k);
            end
        end
    end

endmodule

// File: rtl/univ_rotate_align.sv
// Receive-side rotation aligner: finds the link rotation from a framed sync word,
// confirms it over several frames, then de-rotates every word while locked.
module univ_rotate_align
    import univ_rotate_pkg::*;
#(
    parameter int unsigned   DW         = 8,
    parameter logic [DW-1:0] SYNC_PAT   = DW'(8'hB1),
    parameter int unsigned   FRAME_LEN  = 4,
    parameter int unsigned   LOCK_CNT   = 2,
    parameter int unsigned   UNLOCK_CNT = 2,
    localparam int unsigned  AW         = aw_of(DW)
) (
    input  logic          clk,
    input  logic          sync_rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_sof,
    output logic          locked,
    output logic [AW-1:0] rot_amt
);

    localparam int unsigned PW = $clog2(FRAME_LEN);
    localparam int unsigned HW = $clog2(LOCK_CNT + 1);
    localparam int unsigned MW = $clog2(UNLOCK_CNT + 1);

    localparam logic [PW-1:0] POS_LAST  = PW'(FRAME_LEN - 1);
    localparam logic [HW-1:0] HIT_LOCK  = HW'(LOCK_CNT);
    localparam logic [MW-1:0] MISS_DROP = MW'(UNLOCK_CNT);

    state_e        r_state;
    logic [PW-1:0] r_pos;
    logic [HW-1:0] r_hit_cnt;
    logic [MW-1:0] r_miss_cnt;
    logic [AW-1:0] r_rot_amt;
    logic          r_out_valid;
    logic [DW-1:0] r_out_data;
    logic          r_out_sof;
    logic          r_locked;

    state_e        w_state_nxt;
    logic [PW-1:0] w_pos_nxt;
    logic [HW-1:0] w_hit_nxt;
    logic [MW-1:0] w_miss_nxt;
    logic [AW-1:0] w_rot_nxt;

    logic          w_found;
    logic [AW-1:0] w_find_r;
    logic [DW-1:0] w_derot;
    logic          w_match;
    logic [PW-1:0] w_pos_inc;
    logic [HW-1:0] w_hit_inc;
    logic [MW-1:0] w_miss_inc;
    logic          w_emit;

    univ_rot_find #(
        .DW       (DW),
        .SYNC_PAT (SYNC_PAT)
    ) u_find (
        .i_word  (in_data),
        .o_found (w_found),
        .o_r     (w_find_r)
    );

    assign w_derot    = DW'(rotl(MAX_DW'(in_data), 32'(r_rot_amt), DW));
    assign w_match    = (w_derot == SYNC_PAT);
    assign w_pos_inc  = (r_pos == POS_LAST) ? '0 : r_pos + PW'(1);
    assign w_hit_inc  = r_hit_cnt + HW'(1);
    assign w_miss_inc = r_miss_cnt + MW'(1);
    assign w_emit     = in_valid && (r_state == LOCKED);

    always_comb begin
        w_state_nxt = r_state;
        w_pos_nxt   = r_pos;
        w_hit_nxt   = r_hit_cnt;
        w_miss_nxt  = r_miss_cnt;
        w_rot_nxt   = r_rot_amt;
        if (in_valid) begin
            case (r_state)
                SEARCH: begin
                    if (w_found) begin
                        w_rot_nxt   = w_find_r;
                        w_pos_nxt   = PW'(1);
                        w_hit_nxt   = HW'(1);
                        w_miss_nxt  = '0;
                        w_state_nxt = (LOCK_CNT == 1) ? LOCKED : VERIFY;
                    end
                end
                VERIFY: begin
                    w_pos_nxt = w_pos_inc;
                    if (r_pos == '0) begin
                        if (w_match) begin
                            w_hit_nxt = w_hit_inc;
                            if (w_hit_inc == HIT_LOCK) begin
                                w_state_nxt = LOCKED;
                                w_miss_nxt  = '0;
                            end
                        end else begin
                            // The missing word is deliberately not re-searched this cycle.
                            w_state_nxt = SEARCH;
                            w_pos_nxt   = '0;
                            w_hit_nxt   = '0;
                        end
                    end
                end
                LOCKED: begin
                    w_pos_nxt = w_pos_inc;
                    if (r_pos == '0) begin
                        if (w_match) begin
                            w_miss_nxt = '0;
                        end else begin
                            w_miss_nxt = w_miss_inc;
                            if (w_miss_inc == MISS_DROP) begin
                                w_state_nxt = SEARCH;
                                w_pos_nxt   = '0;
                                w_hit_nxt   = '0;
                            end
                        end
                    end
                end
                default: w_state_nxt = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            r_state     <= SEARCH;
            r_pos       <= '0;
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
            r_rot_amt   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sof   <= 1'b0;
            r_locked    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state     <= w_state_nxt;
            r_pos       <= w_pos_nxt;
            r_hit_cnt   <= w_hit_nxt;
            r_miss_cnt  <= w_miss_nxt;
            r_rot_amt   <= w_rot_nxt;
            r_out_valid <= w_emit;
            r_out_sof   <= w_emit && (r_pos == '0);
            r_locked    <= (w_state_nxt == LOCKED);
            if (w_emit) begin
                r_out_data <= w_derot;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sof   = r_out_sof;
    assign locked    = r_locked;
    assign rot_amt   = r_rot_amt;

endmodule

// File: tb/tb_univ_rotate_align.sv
// Directed bench for univ_rotate_align: scoreboard of expected outputs filled as words are
// driven and drained as the aligner emits them, plus lock/rotation checks at key steps.
module tb_univ_rotate_align;

    logic       clk = 1'b0;
    logic       sync_rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_sof;
    logic       locked;
    logic [2:0] rot_amt;

    int n_checks = 0;
    int n_fail   = 0;
    int cur_rot  = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       sof;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    univ_rotate_align #(
        .DW         (8),
        .SYNC_PAT   (8'hB1),
        .FRAME_LEN  (4),
        .LOCK_CNT   (2),
        .UNLOCK_CNT (2)
    ) dut (
        .clk       (clk),
        .sync_rst  (sync_rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sof   (out_sof),
        .locked    (locked),
        .rot_amt   (rot_amt)
    );

    function automatic logic [7:0] ref_rotl(input logic [7:0] w, input int r);
        logic [7:0] o;
        for (int i = 0; i < 8; i++) o[(i + r) % 8] = w[i];
        return o;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: drive a word (or a bubble), then compare the registered outputs.
    task automatic step(input logic v, input logic [7:0] d, input logic exp_v, input logic exp_sof);
        exp_t e;
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        if (exp_v) exp_q.push_back('{data: ref_rotl(d, cur_rot), sof: exp_sof});
        @(posedge clk);
        #1;
        check("out_valid", 32'(out_valid), 32'(exp_v));
        check("out_sof", 32'(out_sof), 32'(exp_v & exp_sof));
        if (out_valid && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("out_data", 32'(out_data), 32'(e.data));
        end
    endtask

    task automatic send(input logic [7:0] d, input logic exp_v, input logic exp_sof);
        step(1'b1, d, exp_v, exp_sof);
    endtask

    task automatic idle();
        step(1'b0, 8'($urandom), 1'b0, 1'b0);
        check("bubble_rot_hold", 32'(rot_amt), 32'(cur_rot));
    endtask

    task automatic frame(input logic [7:0] p0, input logic exp_v);
        send(p0, exp_v, 1'b1);
        send(8'h11, exp_v, 1'b0);
        send(8'h22, exp_v, 1'b0);
        send(8'h33, exp_v, 1'b0);
    endtask

    // Reset is held for one edge with a valid sync word present, which it must override.
    task automatic do_reset(input string tag);
        @(negedge clk);
        sync_rst = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hB1;
        @(posedge clk);
        #1;
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_data"}, 32'(out_data), 32'd0);
        check({tag, "_out_sof"}, 32'(out_sof), 32'd0);
        check({tag, "_locked"}, 32'(locked), 32'd0);
        check({tag, "_rot_amt"}, 32'(rot_amt), 32'd0);
        @(negedge clk);
        sync_rst = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        sync_rst = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        do_reset("rst_init");

        // Acquire rotation 3: 8'h36 is 8'hB1 rotated right by 3.
        send(8'h36, 1'b0, 1'b0);
        check("search_rot", 32'(rot_amt), 32'd3);
        check("verify_not_locked", 32'(locked), 32'd0);
        cur_rot = 3;
        send(8'h11, 1'b0, 1'b0);
        send(8'h22, 1'b0, 1'b0);
        send(8'h33, 1'b0, 1'b0);
        check("pre_lock", 32'(locked), 32'd0);
        send(8'h36, 1'b0, 1'b0);
        check("locked_rise", 32'(locked), 32'd1);
        send(8'h11, 1'b1, 1'b0);
        send(8'h22, 1'b1, 1'b0);
        send(8'h33, 1'b1, 1'b0);
        frame(8'h36, 1'b1);

        // Bubbles mid-frame: position and rotation hold, no output during gaps.
        send(8'h36, 1'b1, 1'b1);
        idle();
        send(8'h11, 1'b1, 1'b0);
        idle();
        idle();
        send(8'h22, 1'b1, 1'b0);
        send(8'h33, 1'b1, 1'b0);
        frame(8'h36, 1'b1);

        // A single bad sync word is tolerated and still output.
        frame(8'h00, 1'b1);
        check("one_miss_locked", 32'(locked), 32'd1);
        frame(8'h36, 1'b1);

        // Two consecutive misses drop lock; the second bad word is still output.
        frame(8'h01, 1'b1);
        check("first_miss_locked", 32'(locked), 32'd1);
        send(8'h02, 1'b1, 1'b1);
        check("locked_fall", 32'(locked), 32'd0);
        send(8'h11, 1'b0, 1'b0);
        send(8'h22, 1'b0, 1'b0);
        send(8'h33, 1'b0, 1'b0);

        // False verify: candidate found, next sync slot fails, back to search.
        send(8'h36, 1'b0, 1'b0);
        send(8'h11, 1'b0, 1'b0);
        send(8'h22, 1'b0, 1'b0);
        send(8'h33, 1'b0, 1'b0);
        send(8'h00, 1'b0, 1'b0);
        check("false_verify_locked", 32'(locked), 32'd0);
        send(8'h11, 1'b0, 1'b0);
        send(8'h22, 1'b0, 1'b0);
        send(8'h33, 1'b0, 1'b0);

        // Relock, then reset mid-lock.
        frame(8'h36, 1'b0);
        send(8'h36, 1'b0, 1'b0);
        check("relock", 32'(locked), 32'd1);
        send(8'h11, 1'b1, 1'b0);
        do_reset("rst_mid");

        // Zero rotation: output equals input one clock later.
        cur_rot = 0;
        send(8'hB1, 1'b0, 1'b0);
        check("zero_rot_amt", 32'(rot_amt), 32'd0);
        check("zero_first_sync", 32'(locked), 32'd0);
        send(8'h11, 1'b0, 1'b0);
        send(8'h22, 1'b0, 1'b0);
        send(8'h33, 1'b0, 1'b0);
        send(8'hB1, 1'b0, 1'b0);
        check("zero_locked", 32'(locked), 32'd1);
        send(8'h11, 1'b1, 1'b0);
        send(8'h22, 1'b1, 1'b0);
        send(8'h33, 1'b1, 1'b0);
        frame(8'hB1, 1'b1);
        check("zero_rot_final", 32'(rot_amt), 32'd0);

        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
